calendar_ctrl: RTL and testbench

- Date sequencer for the digital clock with date display; owns the day and year registers.
- Drives the existing 1-12 month counter through single-cycle step and load strobes, and reads its value back on month_q.
- Advances the date on the midnight tick from the time-of-day chain, including month lengths and leap years.
- Runs a button-driven set-mode state machine for editing year, month and day.

---
 rtl/calendar_ctrl.sv | 170 +++++++++++++++++
 tb/tb_calendar_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_ctrl.sv
// calendar_ctrl: date sequencer for the digital clock.
//   Owns the day (1-31) and year (0-99 => 2000-2099) registers, advances
//   them on the midnight tick and drives the external 1-12 month counter
//   through single-cycle step/load strobes. A set_btn-driven mode machine
//   (RUN -> SET_YEAR -> SET_MONTH -> SET_DAY -> RUN) lets inc_btn edit
//   each field in turn.
// Ports:
//   clk, clear_n         clock, asynchronous active-low reset
//   day_tick             one-cycle midnight rollover pulse
//   set_btn, inc_btn     one-cycle debounced button pulses
//   month_q              month counter readback (1-12)
//   month_step           one-cycle advance request to the month counter
//   month_load           one-cycle load strobe, month_data is the value
//   day, year, mode      current date and edit mode
//   edit_field           one-hot {day, month, year} blink select
//   busy                 month_q is stale (cycle after a strobe)
module calendar_ctrl #(
  parameter int YEAR_RESET = 24,
  parameter int DAY_RESET  = 1
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       day_tick,
  input  logic       set_btn,
  input  logic       inc_btn,
  input  logic [3:0] month_q,
  output logic       month_step,
  output logic       month_load,
  output logic [3:0] month_data,
  output logic [4:0] day,
  output logic [6:0] year,
  output logic [1:0] mode,
  output logic [2:0] edit_field,
  output logic       busy
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_YEAR  = 2'd1,
    SET_MONTH = 2'd2,
    SET_DAY   = 2'd3
  } mode_e;

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  function automatic logic [6:0] year_inc(input logic [6:0] y);
    return (y >= 7'd99) ? 7'd0 : y + 7'd1;
  endfunction

  mode_e      mode_q, mode_d;
  logic [4:0] day_q, day_d;
  logic [6:0] year_q, year_d;
  logic       step_q, step_d;
  logic       load_q, load_d;
  logic [3:0] mdata_q, mdata_d;
  logic       busy_q, busy_d;
  logic       pend_q, pend_d;
  logic [2:0] field_q, field_d;
  logic [4:0] dim;
  logic       tick_go;

  always_comb begin
    mode_d  = mode_q;
    day_d   = day_q;
    year_d  = year_q;
    step_d  = 1'b0;
    load_d  = 1'b0;
    mdata_d = mdata_q;
    pend_d  = pend_q;
    tick_go = 1'b0;
    dim     = days_in_month(month_q, year_q);
    // month_q is only trustworthy again once the strobe has settled
    busy_d  = step_q | load_q;

    case (mode_q)
      RUN: begin
        // A tick that lands while busy waits in pend_q; extra ticks are lost.
        if (!busy_q) begin
          tick_go = day_tick | pend_q;
          pend_d  = 1'b0;
        end else if (day_tick) begin
          pend_d = 1'b1;
        end
        if (tick_go) begin
          if (day_q < dim) begin
            day_d = day_q + 5'd1;
          end else begin
            day_d  = 5'd1;
            step_d = 1'b1;
            if (month_q == 4'd12) year_d = year_inc(year_q);
          end
        end
        if (set_btn) mode_d = SET_YEAR;
      end
      default: begin
        // Editing freezes the date: ticks (and any pending one) are dropped.
        pend_d = 1'b0;
        if (set_btn) begin
          case (mode_q)
            SET_YEAR:  mode_d = SET_MONTH;
            SET_MONTH: begin
              mode_d = SET_DAY;
              // Month may have shortened since the day was chosen.
              if (day_q > dim) day_d = dim;
            end
            default:   mode_d = RUN;
          endcase
        end else if (inc_btn && !busy_q) begin
          case (mode_q)
            SET_YEAR:  year_d = year_inc(year_q);
            SET_MONTH: begin
              load_d  = 1'b1;
              mdata_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
            end
            default:   day_d = (day_q >= dim) ? 5'd1 : day_q + 5'd1;
          endcase
        end
      end
    endcase

    case (mode_d)
      SET_YEAR:  field_d = 3'b001;
      SET_MONTH: field_d = 3'b010;
      SET_DAY:   field_d = 3'b100;
      default:   field_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      mode_q  <= RUN;
      day_q   <= 5'(DAY_RESET);
      year_q  <= 7'(YEAR_RESET);
      step_q  <= 1'b0;
      load_q  <= 1'b0;
      mdata_q <= 4'd0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      field_q <= 3'b000;
    end else begin
      mode_q  <= mode_d;
      day_q   <= day_d;
      year_q  <= year_d;
      step_q  <= step_d;
      load_q  <= load_d;
      mdata_q <= mdata_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      field_q <= field_d;
    end
  end

  assign month_step = step_q;
  assign month_load = load_q;
  assign month_data = mdata_q;
  assign day        = day_q;
  assign year       = year_q;
  assign mode       = mode_q;
  assign edit_field = field_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_calendar_ctrl.sv
// Testbench for calendar_ctrl: directed date scenarios plus random button /
// tick traffic, checked cycle by cycle against a calendar reference model
// through an expected-value queue.
module tb_calendar_ctrl;

  logic       clk = 1'b0;
  logic       clear_n = 1'b1;
  logic       day_tick = 1'b0;
  logic       set_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [3:0] mq;
  logic       month_step, month_load, busy;
  logic [3:0] month_data;
  logic [4:0] day;
  logic [6:0] year;
  logic [1:0] mode;
  logic [2:0] edit_field;

  calendar_ctrl #(.YEAR_RESET(24), .DAY_RESET(1)) dut (
    .clk(clk), .clear_n(clear_n), .day_tick(day_tick), .set_btn(set_btn),
    .inc_btn(inc_btn), .month_q(mq), .month_step(month_step),
    .month_load(month_load), .month_data(month_data), .day(day), .year(year),
    .mode(mode), .edit_field(edit_field), .busy(busy)
  );

  always #5 clk = ~clk;

  // External month counter, driven by the DUT strobes
  always @(posedge clk or negedge clear_n) begin
    if (!clear_n)        mq <= 4'd1;
    else if (month_step) mq <= (mq == 4'd12) ? 4'd1 : mq + 4'd1;
    else if (month_load) mq <= month_data;
  end

  typedef struct {
    int day; int year; int mode; int edit; int step; int load; int mdata; int busy;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference calendar model
  int m_day, m_year, m_mode, m_mon, m_busy, m_pend, m_step, m_load, m_mdata;
  int month_len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  function automatic int dim_of(input int mon, input int yr);
    if (mon < 1 || mon > 12) return 31;
    if (mon == 2 && (yr % 4) == 0) return 29;
    return month_len[mon-1];
  endfunction

  task automatic model_reset();
    m_day = 1; m_year = 24; m_mode = 0; m_mon = 1;
    m_busy = 0; m_pend = 0; m_step = 0; m_load = 0; m_mdata = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit i);
    int dm, n_day, n_year, n_mode, n_pend, n_step, n_load, n_mdata, n_mon;
    exp_t e;
    dm = dim_of(m_mon, m_year);
    n_day = m_day; n_year = m_year; n_mode = m_mode; n_pend = m_pend;
    n_step = 0; n_load = 0; n_mdata = m_mdata;
    if (m_mode == 0) begin
      if (!m_busy) begin
        if (t || m_pend) begin
          if (m_day < dm) n_day = m_day + 1;
          else begin
            n_day = 1;
            n_step = 1;
            if (m_mon == 12) n_year = (m_year + 1) % 100;
          end
        end
        n_pend = 0;
      end else if (t) n_pend = 1;
      if (s) n_mode = 1;
    end else begin
      n_pend = 0;
      if (s) begin
        n_mode = (m_mode + 1) % 4;
        if (n_mode == 3 && m_day > dm) n_day = dm;
      end else if (i && !m_busy) begin
        if (m_mode == 1) n_year = (m_year + 1) % 100;
        else if (m_mode == 2) begin
          n_load = 1;
          n_mdata = (m_mon % 12) + 1;
        end else n_day = (m_day >= dm) ? 1 : m_day + 1;
      end
    end
    n_mon = m_step ? (m_mon % 12) + 1 : (m_load ? m_mdata : m_mon);
    m_busy = (m_step || m_load) ? 1 : 0;
    m_day = n_day; m_year = n_year; m_mode = n_mode; m_pend = n_pend;
    m_step = n_step; m_load = n_load; m_mdata = n_mdata; m_mon = n_mon;
    e.day = m_day; e.year = m_year; e.mode = m_mode;
    e.edit = (m_mode == 0) ? 0 : (1 << (m_mode - 1));
    e.step = m_step; e.load = m_load; e.mdata = m_mdata; e.busy = m_busy;
    sb.push_back(e);
  endtask

  // Monitor: compares every post-edge DUT state with the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("day", int'(day), e.day);
        check("year", int'(year), e.year);
        check("mode", int'(mode), e.mode);
        check("edit_field", int'(edit_field), e.edit);
        check("month_step", int'(month_step), e.step);
        check("month_load", int'(month_load), e.load);
        check("busy", int'(busy), e.busy);
        if (e.load != 0) check("month_data", int'(month_data), e.mdata);
      end
    end
  end

  task automatic drive(input bit t, input bit s, input bit i);
    @(negedge clk);
    day_tick = t; set_btn = s; inc_btn = i;
    model_step(t, s, i);
    @(posedge clk);
  endtask

  task automatic spot(input string name, input int act_unused_delay, input int exp);
    check(name, act_unused_delay, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    day_tick = 0; set_btn = 0; inc_btn = 0;
    clear_n = 1'b0;
    #1;
    check("rst_day", int'(day), 1);
    check("rst_year", int'(year), 24);
    check("rst_mode", int'(mode), 0);
    check("rst_edit", int'(edit_field), 0);
    check("rst_step", int'(month_step), 0);
    check("rst_load", int'(month_load), 0);
    check("rst_mdata", int'(month_data), 0);
    check("rst_busy", int'(busy), 0);
    model_reset();
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
  endtask

  // Walks the edit modes from RUN to reach the requested date, back in RUN.
  task automatic set_date(input int y, input int m, input int d);
    drive(0, 1, 0);
    while (m_year != y) drive(0, 0, 1);
    drive(0, 1, 0);
    while (m_mon != m) begin
      drive(0, 0, 1); drive(0, 0, 0); drive(0, 0, 0);
    end
    drive(0, 1, 0);
    while (m_day != d) drive(0, 0, 1);
    drive(0, 1, 0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // January: 30 ticks walk day 1 -> 31 without a month step
    repeat (30) drive(1, 0, 0);
    #2;
    spot("jan_day31", int'(day), 31);
    spot("jan_no_step", int'(month_step), 0);

    // Month rollover, then a tick during busy is deferred
    drive(1, 0, 0);
    #2;
    spot("roll_day", int'(day), 1);
    spot("roll_step", int'(month_step), 1);
    drive(0, 0, 0);
    #2;
    spot("roll_busy", int'(busy), 1);
    spot("roll_step_off", int'(month_step), 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    #2;
    spot("pend_day", int'(day), 2);

    // Dec 31 2099 -> Jan 1 2000
    set_date(99, 12, 31);
    drive(1, 0, 0);
    #2;
    spot("ny_day", int'(day), 1);
    spot("ny_year", int'(year), 0);
    spot("ny_step", int'(month_step), 1);
    drive(0, 0, 0); drive(0, 0, 0);

    // February leap / non-leap
    set_date(24, 2, 28);
    drive(1, 0, 0);
    #2;
    spot("feb24_29", int'(day), 29);
    drive(1, 0, 0);
    #2;
    spot("feb24_roll", int'(day), 1);
    spot("feb24_step", int'(month_step), 1);
    drive(0, 0, 0); drive(0, 0, 0);
    set_date(23, 2, 28);
    drive(1, 0, 0);
    #2;
    spot("feb23_roll", int'(day), 1);
    spot("feb23_step", int'(month_step), 1);
    drive(0, 0, 0); drive(0, 0, 0);

    // Year wrap in SET_YEAR, month wrap load in SET_MONTH
    drive(0, 1, 0);
    while (m_year != 98) drive(0, 0, 1);
    drive(0, 0, 1);
    #2; spot("sety_99", int'(year), 99);
    drive(0, 0, 1);
    #2; spot("sety_0", int'(year), 0);
    drive(0, 0, 1);
    #2; spot("sety_1", int'(year), 1);
    drive(0, 1, 0);
    while (m_mon != 12) begin
      drive(0, 0, 1); drive(0, 0, 0); drive(0, 0, 0);
    end
    drive(0, 0, 1);
    #2;
    spot("setm_load", int'(month_load), 1);
    spot("setm_data", int'(month_data), 1);
    drive(0, 0, 0);
    drive(0, 0, 1);
    #2; spot("setm_drop", int'(month_load), 0);
    drive(0, 0, 0);
    #2; spot("setm_month", int'(mq), 1);
    drive(0, 1, 0); drive(0, 1, 0);

    // Day clamp on entry into SET_DAY, ticks frozen while editing
    set_date(24, 1, 31);
    drive(0, 1, 0); drive(0, 1, 0);
    while (m_mon != 4) begin
      drive(0, 0, 1); drive(0, 0, 0); drive(0, 0, 0);
    end
    drive(0, 1, 0);
    #2;
    spot("clamp_day", int'(day), 30);
    spot("clamp_edit", int'(edit_field), 4);
    drive(0, 0, 1);
    #2; spot("setd_wrap", int'(day), 1);
    drive(1, 0, 0);
    #2; spot("setd_frozen", int'(day), 1);
    drive(0, 1, 0);
    #2; spot("back_run", int'(mode), 0);

    // Reset while month_step is high
    set_date(24, 4, 30);
    drive(1, 0, 0);
    do_reset();

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 2) == 0);
      if (n % 1000 == 999) do_reset();
    end
    drive(0, 0, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
